// File: rtl/mfcc_frame_scheduler.sv
// mfcc_frame_scheduler
//   Sequences one MFCC frame through the stages
//   window move -> Hamming -> FFT -> Mel -> DCT.
//   Counts samples written to the PCM FIFO and launches a frame once enough
//   new samples exist: FRAME_SIZE for the first frame after priming and
//   FRAME_MOVE (one hop) for every later frame. Each stage gets a one-cycle
//   start pulse on entry and the scheduler waits for that stage's done.
//   Overruns (producer more than two hops ahead) drop a hop and are counted.
//   A per-stage watchdog returns to IDLE and raises a sticky timeout flag.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable_i                       run enable; low while IDLE re-primes
//   sample_valid_i                 one sample written to the FIFO
//   <stage>_start_o / _done_i      per-stage start pulse / completion
//                                  (move, hamming, fft, mel, dct)
//   frame_done_o                   one-cycle pulse per completed frame
//   frame_count_o                  completed frames (wraps)
//   dropped_count_o                dropped hops (saturates)
//   timeout_o                      sticky stage-timeout flag
//   busy_o                         high whenever stage_o is not IDLE
//   stage_o                        0 IDLE, 1 MOVE, 2 HAM, 3 FFT, 4 MEL, 5 DCT
module mfcc_frame_scheduler #(
  parameter int FRAME_SIZE     = 400,
  parameter int FRAME_MOVE     = 160,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 sample_valid_i,
  output logic                 move_start_o,
  input  logic                 move_done_i,
  output logic                 hamming_start_o,
  input  logic                 hamming_done_i,
  output logic                 fft_start_o,
  input  logic                 fft_done_i,
  output logic                 mel_start_o,
  input  logic                 mel_done_i,
  output logic                 dct_start_o,
  input  logic                 dct_done_i,
  output logic                 frame_done_o,
  output logic [CNT_WIDTH-1:0] frame_count_o,
  output logic [CNT_WIDTH-1:0] dropped_count_o,
  output logic                 timeout_o,
  output logic                 busy_o,
  output logic [2:0]           stage_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MOVE = 3'd1;
  localparam logic [2:0] ST_HAM  = 3'd2;
  localparam logic [2:0] ST_FFT  = 3'd3;
  localparam logic [2:0] ST_MEL  = 3'd4;
  localparam logic [2:0] ST_DCT  = 3'd5;

  // avail never exceeds 2*FRAME_MOVE+1 while busy, nor FRAME_SIZE+1 while
  // waiting for the first launch; size for the larger plus headroom.
  localparam int AVAIL_MAX = (FRAME_SIZE > 2 * FRAME_MOVE) ? FRAME_SIZE : 2 * FRAME_MOVE;
  localparam int AVAIL_W   = $clog2(AVAIL_MAX + 2);
  localparam int WD_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [AVAIL_W-1:0] SIZE_C     = AVAIL_W'(FRAME_SIZE);
  localparam logic [AVAIL_W-1:0] MOVE_C     = AVAIL_W'(FRAME_MOVE);
  localparam logic [AVAIL_W-1:0] OVERRUN_C  = AVAIL_W'(2 * FRAME_MOVE);
  localparam logic [AVAIL_W-1:0] REFILL_C   = AVAIL_W'(FRAME_MOVE + 1);
  localparam logic [WD_W-1:0]    WD_LAST_C  = WD_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]           stage_reg, stage_next;
  logic [4:0]           start_reg, start_next;
  logic                 frame_done_reg, frame_done_next;
  logic [CNT_WIDTH-1:0] frame_count_reg, frame_count_next;
  logic [CNT_WIDTH-1:0] dropped_reg, dropped_next;
  logic                 timeout_reg, timeout_next;
  logic [AVAIL_W-1:0]   avail_reg, avail_next;
  logic                 first_reg, first_next;
  logic [WD_W-1:0]      wd_reg, wd_next;

  // Done inputs ordered like the stage codes (bit 0 = MOVE ... bit 4 = DCT).
  logic [4:0] done_vec;
  logic [4:0] stage_done;
  logic       cur_done;

  assign done_vec = {dct_done_i, mel_done_i, fft_done_i, hamming_done_i, move_done_i};

  // Only the done belonging to the current stage is honoured.
  generate
    for (genvar gi = 0; gi < 5; gi++) begin : g_done
      assign stage_done[gi] = (stage_reg == 3'(gi + 1)) && done_vec[gi];
    end
  endgenerate

  assign cur_done = |stage_done;

  logic               idle;
  logic [AVAIL_W-1:0] need;
  logic               launch;
  logic               sample_in;

  assign idle      = (stage_reg == ST_IDLE);
  assign need      = first_reg ? SIZE_C : MOVE_C;
  assign launch    = idle && enable_i && (avail_reg >= need);
  assign sample_in = enable_i && sample_valid_i;

  always_comb begin
    stage_next       = stage_reg;
    start_next       = '0;
    frame_done_next  = 1'b0;
    frame_count_next = frame_count_reg;
    dropped_next     = dropped_reg;
    timeout_next     = timeout_reg;
    avail_next       = avail_reg;
    first_next       = first_reg;
    wd_next          = wd_reg;

    // Sample accounting and launch
    if (idle && !enable_i) begin
      // Disabled while idle: re-prime so the next run waits for a full frame.
      avail_next   = '0;
      first_next   = 1'b1;
      timeout_next = 1'b0;
    end else if (launch) begin
      // A sample arriving in the launch cycle is carried into the next hop.
      avail_next = avail_reg - need + AVAIL_W'(sample_valid_i);
      first_next = 1'b0;
      stage_next = ST_MOVE;
      start_next = 5'b00001;
      wd_next    = '0;
    end else if (sample_in) begin
      if (!idle && (avail_reg == OVERRUN_C)) begin
        // Producer is two hops ahead: discard one hop, keep counting.
        avail_next = REFILL_C;
        if (dropped_reg != '1) begin
          dropped_next = dropped_reg + CNT_WIDTH'(1);
        end
      end else begin
        avail_next = avail_reg + AVAIL_W'(1);
      end
    end

    // Stage sequencing and watchdog
    if (!idle) begin
      if (cur_done) begin
        wd_next = '0;
        if (stage_reg == ST_DCT) begin
          stage_next       = ST_IDLE;
          frame_done_next  = 1'b1;
          frame_count_next = frame_count_reg + CNT_WIDTH'(1);
        end else begin
          stage_next = stage_reg + 3'd1;
          // Stage code s (1-based) maps to start bit s-1, so the next
          // stage's bit index equals the current stage code.
          start_next = 5'b00001 << stage_reg;
        end
      end else if (wd_reg == WD_LAST_C) begin
        stage_next   = ST_IDLE;
        timeout_next = 1'b1;
        wd_next      = '0;
      end else begin
        wd_next = wd_reg + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_reg       <= ST_IDLE;
      start_reg       <= '0;
      frame_done_reg  <= 1'b0;
      frame_count_reg <= '0;
      dropped_reg     <= '0;
      timeout_reg     <= 1'b0;
      avail_reg       <= '0;
      first_reg       <= 1'b1;
      wd_reg          <= '0;
    end else begin
      stage_reg       <= stage_next;
      start_reg       <= start_next;
      frame_done_reg  <= frame_done_next;
      frame_count_reg <= frame_count_next;
      dropped_reg     <= dropped_next;
      timeout_reg     <= timeout_next;
      avail_reg       <= avail_next;
      first_reg       <= first_next;
      wd_reg          <= wd_next;
    end
  end

  assign move_start_o    = start_reg[0];
  assign hamming_start_o = start_reg[1];
  assign fft_start_o     = start_reg[2];
  assign mel_start_o     = start_reg[3];
  assign dct_start_o     = start_reg[4];
  assign frame_done_o    = frame_done_reg;
  assign frame_count_o   = frame_count_reg;
  assign dropped_count_o = dropped_reg;
  assign timeout_o       = timeout_reg;
  assign busy_o          = (stage_reg != ST_IDLE);
  assign stage_o         = stage_reg;

endmodule

// File: tb/tb_mfcc_frame_scheduler.sv
// Directed testbench for mfcc_frame_scheduler.
// Main instance uses a long watchdog so stalls in the overrun scenario do not
// time out; a second instance with TIMEOUT_CYCLES=100 shares all inputs and
// is only examined in the timeout scenario.
module tb_mfcc_frame_scheduler;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic sv = 1'b0;
  logic [4:0] dones = 5'b0;

  logic          s_move, s_ham, s_fft, s_mel, s_dct;
  logic          frame_done, timeout, busy;
  logic [CW-1:0] frame_count, dropped;
  logic [2:0]    stage;
  logic [4:0]    starts;

  logic          t_move, t_ham, t_fft, t_mel, t_dct;
  logic          t_frame_done, t_timeout, t_busy;
  logic [CW-1:0] t_frame_count, t_dropped;
  logic [2:0]    t_stage;

  int total = 0;
  int bad = 0;

  assign starts = {s_dct, s_mel, s_fft, s_ham, s_move};

  always #5 clk = ~clk;

  mfcc_frame_scheduler #(.FRAME_SIZE(400), .FRAME_MOVE(160), .TIMEOUT_CYCLES(1000), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(sv),
    .move_start_o(s_move), .move_done_i(dones[0]),
    .hamming_start_o(s_ham), .hamming_done_i(dones[1]),
    .fft_start_o(s_fft), .fft_done_i(dones[2]),
    .mel_start_o(s_mel), .mel_done_i(dones[3]),
    .dct_start_o(s_dct), .dct_done_i(dones[4]),
    .frame_done_o(frame_done), .frame_count_o(frame_count),
    .dropped_count_o(dropped), .timeout_o(timeout),
    .busy_o(busy), .stage_o(stage)
  );

  mfcc_frame_scheduler #(.FRAME_SIZE(400), .FRAME_MOVE(160), .TIMEOUT_CYCLES(100), .CNT_WIDTH(CW)) dut_to (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(sv),
    .move_start_o(t_move), .move_done_i(dones[0]),
    .hamming_start_o(t_ham), .hamming_done_i(dones[1]),
    .fft_start_o(t_fft), .fft_done_i(dones[2]),
    .mel_start_o(t_mel), .mel_done_i(dones[3]),
    .dct_start_o(t_dct), .dct_done_i(dones[4]),
    .frame_done_o(t_frame_done), .frame_count_o(t_frame_count),
    .dropped_count_o(t_dropped), .timeout_o(t_timeout),
    .busy_o(t_busy), .stage_o(t_stage)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b0;
    tick;
    tick;
    total++;
    if ({starts, frame_done, frame_count, dropped, timeout, busy, stage} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got starts=%b fd=%b cnt=%0d drop=%0d to=%b busy=%b stage=%0d, want all zero",
               starts, frame_done, frame_count, dropped, timeout, busy, stage);
    end
    rst_n = 1'b1;
    tick;
    $display("test_reset complete");
  endtask

  // T1: 399 samples do not launch, the 400th does.
  task automatic test_first_launch;
    logic early;
    early = 1'b0;
    enable = 1'b1;
    sv = 1'b1;
    repeat (399) begin
      tick;
      if (s_move || stage != 3'd0) early = 1'b1;
    end
    sv = 1'b0;
    total++;
    if (early !== 1'b0 || dut.avail_reg !== 399) begin
      bad++;
      $display("FAIL t1_no_early_launch: got early=%b avail=%0d, want early=0 avail=399", early, dut.avail_reg);
    end
    sv = 1'b1;
    tick;
    sv = 1'b0;
    total++;
    if (s_move !== 1'b0 || stage !== 3'd0) begin
      bad++;
      $display("FAIL t1_launch_cycle: got move_start=%b stage=%0d, want 0/0", s_move, stage);
    end
    tick;
    total++;
    if (starts !== 5'b00001 || stage !== 3'd1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL t1_move_start: got starts=%b stage=%0d busy=%b, want 00001/1/1", starts, stage, busy);
    end
    total++;
    if (dut.avail_reg !== 0) begin
      bad++;
      $display("FAIL t1_avail_after_launch: got %0d want 0", dut.avail_reg);
    end
    $display("test_first_launch complete");
  endtask

  // T2: done returned 3 cycles after each start, with a foreign done injected.
  task automatic test_frame_sequence;
    logic [4:0] exp_start;
    for (int k = 0; k < 5; k++) begin
      exp_start = 5'b00001 << k;
      total++;
      if (starts !== exp_start || stage !== 3'(k + 1)) begin
        bad++;
        $display("FAIL t2_stage_entry_%0d: got starts=%b stage=%0d, want %b/%0d", k, starts, stage, exp_start, k + 1);
      end
      tick;
      total++;
      if (starts !== 5'b0) begin
        bad++;
        $display("FAIL t2_pulse_width_%0d: got starts=%b want 00000", k, starts);
      end
      dones = 5'b00001 << ((k + 2) % 5);
      tick;
      dones = 5'b0;
      total++;
      if (stage !== 3'(k + 1)) begin
        bad++;
        $display("FAIL t2_foreign_done_%0d: got stage=%0d want %0d", k, stage, k + 1);
      end
      tick;
      dones = exp_start;
      tick;
      dones = 5'b0;
    end
    total++;
    if (frame_done !== 1'b1 || frame_count !== 16'd1 || stage !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t2_frame_done: got fd=%b cnt=%0d stage=%0d busy=%b, want 1/1/0/0", frame_done, frame_count, stage, busy);
    end
    tick;
    total++;
    if (frame_done !== 1'b0 || frame_count !== 16'd1) begin
      bad++;
      $display("FAIL t2_frame_done_pulse: got fd=%b cnt=%0d, want 0/1", frame_done, frame_count);
    end
    sv = 1'b1;
    repeat (160) tick;
    sv = 1'b0;
    total++;
    if (starts !== 5'b0 || stage !== 3'd0) begin
      bad++;
      $display("FAIL t2_hop_launch_cycle: got starts=%b stage=%0d, want 00000/0", starts, stage);
    end
    tick;
    total++;
    if (starts !== 5'b00001 || stage !== 3'd1) begin
      bad++;
      $display("FAIL t2_second_launch: got starts=%b stage=%0d, want 00001/1", starts, stage);
    end
    $display("test_frame_sequence complete");
  endtask

  // T3: FFT stalled while 321 samples arrive -> one dropped hop, avail=161.
  task automatic test_overrun;
    dones = 5'b00001;
    tick;
    total++;
    if (starts !== 5'b00010 || stage !== 3'd2) begin
      bad++;
      $display("FAIL t3_done_in_start_cycle: got starts=%b stage=%0d, want 00010/2", starts, stage);
    end
    dones = 5'b00010;
    tick;
    dones = 5'b0;
    total++;
    if (starts !== 5'b00100 || stage !== 3'd3) begin
      bad++;
      $display("FAIL t3_fft_entry: got starts=%b stage=%0d, want 00100/3", starts, stage);
    end
    sv = 1'b1;
    repeat (320) tick;
    total++;
    if (dropped !== 16'd0 || dut.avail_reg !== 320) begin
      bad++;
      $display("FAIL t3_pre_overrun: got dropped=%0d avail=%0d, want 0/320", dropped, dut.avail_reg);
    end
    tick;
    sv = 1'b0;
    total++;
    if (dropped !== 16'd1 || dut.avail_reg !== 161 || stage !== 3'd3) begin
      bad++;
      $display("FAIL t3_overrun: got dropped=%0d avail=%0d stage=%0d, want 1/161/3", dropped, dut.avail_reg, stage);
    end
    dones = 5'b00100;
    tick;
    dones = 5'b01000;
    tick;
    dones = 5'b10000;
    tick;
    dones = 5'b0;
    total++;
    if (frame_done !== 1'b1 || frame_count !== 16'd2 || stage !== 3'd0) begin
      bad++;
      $display("FAIL t3_frame_done: got fd=%b cnt=%0d stage=%0d, want 1/2/0", frame_done, frame_count, stage);
    end
    tick;
    total++;
    if (starts !== 5'b00001 || stage !== 3'd1 || dut.avail_reg !== 1) begin
      bad++;
      $display("FAIL t3_back_to_back: got starts=%b stage=%0d avail=%0d, want 00001/1/1", starts, stage, dut.avail_reg);
    end
    $display("test_overrun complete");
  endtask

  // T5: avail 159 in IDLE, one sample launches; launch-cycle sample is kept.
  task automatic test_launch_sample;
    for (int k = 0; k < 5; k++) begin
      dones = 5'b00001 << k;
      tick;
    end
    dones = 5'b0;
    total++;
    if (frame_count !== 16'd3 || stage !== 3'd0) begin
      bad++;
      $display("FAIL t5_frame3: got cnt=%0d stage=%0d, want 3/0", frame_count, stage);
    end
    sv = 1'b1;
    repeat (158) tick;
    sv = 1'b0;
    total++;
    if (dut.avail_reg !== 159 || stage !== 3'd0 || starts !== 5'b0) begin
      bad++;
      $display("FAIL t5_below_hop: got avail=%0d stage=%0d starts=%b, want 159/0/00000", dut.avail_reg, stage, starts);
    end
    sv = 1'b1;
    tick;
    total++;
    if (stage !== 3'd0 || starts !== 5'b0) begin
      bad++;
      $display("FAIL t5_launch_cycle: got stage=%0d starts=%b, want 0/00000", stage, starts);
    end
    tick;
    sv = 1'b0;
    total++;
    if (starts !== 5'b00001 || dut.avail_reg !== 1) begin
      bad++;
      $display("FAIL t5_kept_sample: got starts=%b avail=%0d, want 00001/1", starts, dut.avail_reg);
    end
    $display("test_launch_sample complete");
  endtask

  // T6: asynchronous reset mid-frame, then a full 400 samples are required.
  task automatic test_async_reset;
    logic early;
    dones = 5'b00001;
    tick;
    dones = 5'b00010;
    tick;
    dones = 5'b0;
    total++;
    if (stage !== 3'd3) begin
      bad++;
      $display("FAIL t6_in_fft: got stage=%0d want 3", stage);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({starts, frame_done, frame_count, dropped, timeout, busy, stage} !== '0) begin
      bad++;
      $display("FAIL t6_async_reset: got starts=%b fd=%b cnt=%0d drop=%0d to=%b busy=%b stage=%0d, want all zero",
               starts, frame_done, frame_count, dropped, timeout, busy, stage);
    end
    tick;
    rst_n = 1'b1;
    early = 1'b0;
    sv = 1'b1;
    repeat (399) begin
      tick;
      if (s_move || stage != 3'd0) early = 1'b1;
    end
    sv = 1'b0;
    tick;
    total++;
    if (early !== 1'b0 || stage !== 3'd0) begin
      bad++;
      $display("FAIL t6_reprimed: got early=%b stage=%0d, want 0/0", early, stage);
    end
    sv = 1'b1;
    tick;
    sv = 1'b0;
    tick;
    total++;
    if (starts !== 5'b00001 || stage !== 3'd1) begin
      bad++;
      $display("FAIL t6_launch_after_400: got starts=%b stage=%0d, want 00001/1", starts, stage);
    end
    $display("test_async_reset complete");
  endtask

  // T4: withhold hamming done on the 100-cycle instance.
  task automatic test_timeout;
    logic early;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    enable = 1'b1;
    sv = 1'b1;
    repeat (400) tick;
    sv = 1'b0;
    tick;
    tick;
    for (int k = 0; k < 5; k++) begin
      dones = 5'b00001 << k;
      tick;
    end
    dones = 5'b0;
    total++;
    if (t_frame_count !== 16'd1 || t_stage !== 3'd0) begin
      bad++;
      $display("FAIL t4_first_frame: got cnt=%0d stage=%0d, want 1/0", t_frame_count, t_stage);
    end
    sv = 1'b1;
    repeat (160) tick;
    sv = 1'b0;
    tick;
    tick;
    dones = 5'b00001;
    tick;
    dones = 5'b0;
    total++;
    if (t_stage !== 3'd2 || t_ham !== 1'b1) begin
      bad++;
      $display("FAIL t4_ham_entry: got stage=%0d ham_start=%b, want 2/1", t_stage, t_ham);
    end
    early = 1'b0;
    for (int i = 1; i < 100; i++) begin
      tick;
      if (t_timeout || t_stage != 3'd2 || t_frame_done) early = 1'b1;
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL t4_no_early_timeout: got early=%b want 0", early);
    end
    tick;
    total++;
    if (t_timeout !== 1'b1 || t_stage !== 3'd0 || t_busy !== 1'b0 || t_frame_count !== 16'd1 || t_frame_done !== 1'b0) begin
      bad++;
      $display("FAIL t4_timeout: got to=%b stage=%0d busy=%b cnt=%0d fd=%b, want 1/0/0/1/0",
               t_timeout, t_stage, t_busy, t_frame_count, t_frame_done);
    end
    total++;
    if (timeout !== 1'b0 || stage !== 3'd2) begin
      bad++;
      $display("FAIL t4_long_watchdog: got to=%b stage=%0d, want 0/2", timeout, stage);
    end
    tick;
    total++;
    if (t_timeout !== 1'b1) begin
      bad++;
      $display("FAIL t4_sticky: got to=%b want 1", t_timeout);
    end
    enable = 1'b0;
    tick;
    tick;
    total++;
    if (t_timeout !== 1'b0) begin
      bad++;
      $display("FAIL t4_clear_on_disable: got to=%b want 0", t_timeout);
    end
    $display("test_timeout complete");
  endtask

  initial begin
    test_reset;
    test_first_launch;
    test_frame_sequence;
    test_overrun;
    test_launch_sample;
    test_async_reset;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
